// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC decimator controller.
package cic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_RUN
  } cic_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cic_out_fifo.sv
// Synchronous power-of-two FIFO buffering decimator output for the stream port.
module cic_out_fifo
  import cic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_pop, w_push;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cic_d_ctrl.sv
// Run-control for a CIC decimator: clear pulse, settle discard, then buffered
// valid/ready delivery of decimated samples.
module cic_d_ctrl
  import cic_pkg::*;
#(
  parameter int INP_DW     = 18,
  parameter int OUT_DW     = 18,
  parameter int CIC_N      = 7,
  parameter int CIC_M      = 1,
  parameter int CLR_CYC    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [INP_DW-1:0] inp_samp_data,
  input  logic              inp_samp_str,
  output logic [INP_DW-1:0] cic_inp_samp_data,
  output logic              cic_inp_samp_str,
  output logic              cic_clear,
  input  logic [OUT_DW-1:0] cic_out_samp_data,
  input  logic              cic_out_samp_str,
  output logic [OUT_DW-1:0] out_tdata,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic              busy,
  output logic              overflow,
  output logic              settled
);

  localparam int SET_INIT = CIC_N * CIC_M;
  localparam int SW       = clog2(SET_INIT + 1);
  localparam int CW       = (clog2(CLR_CYC + 1) < 1) ? 1 : clog2(CLR_CYC + 1);
  localparam logic [SW-1:0] SET_LOAD = SW'(SET_INIT);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

  cic_state_e    r_state;
  logic [CW-1:0] r_clr_cnt;
  logic [SW-1:0] r_set_cnt;
  logic          r_ovf, r_settled;
  logic          w_push, w_pop, w_full, w_empty, w_drop, w_live;

  assign w_live            = (r_state == ST_SETTLE) | (r_state == ST_RUN);
  assign cic_inp_samp_data = inp_samp_data;
  assign cic_inp_samp_str  = inp_samp_str & w_live;
  assign cic_clear         = (r_state == ST_CLEAR);
  assign busy              = (r_state != ST_IDLE);
  assign overflow          = r_ovf;
  assign settled           = r_settled;

  assign out_tvalid = ~w_empty;
  assign w_pop      = out_tvalid & out_tready;
  assign w_push     = (r_state == ST_RUN) & cic_out_samp_str;
  assign w_drop     = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_set_cnt <= '0;
      r_ovf     <= 1'b0;
      r_settled <= 1'b0;
    end else begin
      r_settled <= 1'b0;
      if (w_drop) r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_set_cnt <= SET_LOAD;
            r_ovf     <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (stop) r_state <= ST_IDLE;
          else if (r_clr_cnt == CLR_LAST) begin
            r_state   <= ST_SETTLE;
            r_clr_cnt <= '0;
          end else r_clr_cnt <= r_clr_cnt + 1'b1;
        end
        ST_SETTLE: begin
          // Samples still carrying pre-clear history are counted off, not kept.
          if (stop) r_state <= ST_IDLE;
          else if (cic_out_samp_str) begin
            r_set_cnt <= r_set_cnt - 1'b1;
            if (r_set_cnt == SW'(1)) begin
              r_state   <= ST_RUN;
              r_settled <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  cic_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (OUT_DW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (cic_out_samp_data),
    .o_data  (out_tdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_cic_d_ctrl.sv
// Self-checking bench for cic_d_ctrl: directed scenarios plus a random run
// against a queue-based behavioural model.
module tb_cic_d_ctrl;

  localparam int INP_DW     = 18;
  localparam int OUT_DW     = 18;
  localparam int CIC_N      = 7;
  localparam int CIC_M      = 1;
  localparam int CLR_CYC    = 2;
  localparam int FIFO_DEPTH = 4;

  localparam int P_IDLE = 0, P_CLEAR = 1, P_SETTLE = 2, P_RUN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [INP_DW-1:0] inp_samp_data = '0;
  logic              inp_samp_str = 1'b0;
  logic [INP_DW-1:0] cic_inp_samp_data;
  logic              cic_inp_samp_str, cic_clear;
  logic [OUT_DW-1:0] cic_out_samp_data = '0;
  logic              cic_out_samp_str = 1'b0;
  logic [OUT_DW-1:0] out_tdata;
  logic              out_tvalid;
  logic              out_tready = 1'b0;
  logic              busy, overflow, settled;

  cic_d_ctrl #(
    .INP_DW(INP_DW), .OUT_DW(OUT_DW), .CIC_N(CIC_N), .CIC_M(CIC_M),
    .CLR_CYC(CLR_CYC), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .inp_samp_data(inp_samp_data), .inp_samp_str(inp_samp_str),
    .cic_inp_samp_data(cic_inp_samp_data), .cic_inp_samp_str(cic_inp_samp_str),
    .cic_clear(cic_clear),
    .cic_out_samp_data(cic_out_samp_data), .cic_out_samp_str(cic_out_samp_str),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .busy(busy), .overflow(overflow), .settled(settled)
  );

  int checks = 0, failures = 0;

  // Behavioural model: phase, remaining clear cycles, remaining settle samples, buffer.
  int              m_ph = P_IDLE, m_clr = 0, m_set = 0;
  bit              m_ovf = 0, m_settled = 0;
  logic [OUT_DW-1:0] m_q[$];
  logic [OUT_DW-1:0] got[$];
  int              n_settled = 0;

  task automatic cyc();
    int nph, ncl, nse;
    bit nov, nst, full, pop;
    nph = m_ph; ncl = m_clr; nse = m_set; nov = m_ovf; nst = 0;
    if (out_tvalid && out_tready) got.push_back(out_tdata);
    if (reset) begin
      nph = P_IDLE; ncl = 0; nse = 0; nov = 0; m_q.delete();
    end else begin
      full = (m_q.size() == FIFO_DEPTH);
      pop  = (m_q.size() != 0) && out_tready;
      if (pop) void'(m_q.pop_front());
      if (m_ph == P_RUN && cic_out_samp_str) begin
        if (full && !pop) nov = 1;
        else m_q.push_back(cic_out_samp_data);
      end
      if (m_ph == P_IDLE) begin
        if (start && !stop) begin
          nph = P_CLEAR; ncl = CLR_CYC; nse = CIC_N * CIC_M; nov = 0;
        end
      end else if (stop) nph = P_IDLE;
      else if (m_ph == P_CLEAR) begin
        ncl = m_clr - 1;
        if (ncl == 0) nph = P_SETTLE;
      end else if (m_ph == P_SETTLE && cic_out_samp_str) begin
        nse = m_set - 1;
        if (nse == 0) begin nph = P_RUN; nst = 1; end
      end
    end
    @(posedge clk); #1;
    m_ph = nph; m_clr = ncl; m_set = nse; m_ovf = nov; m_settled = nst;
    if (settled) n_settled++;
  endtask

  task automatic strobe(input logic [OUT_DW-1:0] v);
    cic_out_samp_str = 1'b1; cic_out_samp_data = v;
    cyc();
    cic_out_samp_str = 1'b0;
  endtask

  task automatic do_reset();
    start = 0; stop = 0; cic_out_samp_str = 0; inp_samp_str = 0; out_tready = 0;
    reset = 1; cyc(); reset = 0;
  endtask

  task automatic go_run();
    start = 1; cyc(); start = 0;
    repeat (CLR_CYC) cyc();
    for (int i = 0; i < CIC_N * CIC_M; i++) strobe(OUT_DW'($urandom));
  endtask

  task automatic test_reset();
    reset = 1; cyc(); cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cic_clear !== 1'b0) begin failures++; $display("FAIL reset_clear got=%b exp=0", cic_clear); end
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", out_tvalid); end
    checks++; if (out_tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", out_tdata); end
    checks++; if (overflow !== 1'b0 || settled !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", overflow, settled); end
    reset = 0;
  endtask

  task automatic test_clear_seq();
    do_reset();
    start = 1; cyc(); start = 0;
    for (int c = 1; c <= CLR_CYC + 2; c++) begin
      checks++;
      if (cic_clear !== (c <= CLR_CYC)) begin failures++; $display("FAIL clear_cyc%0d got=%b exp=%b", c, cic_clear, c <= CLR_CYC); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy_cyc%0d got=%b exp=1", c, busy); end
      cyc();
    end
  endtask

  task automatic test_settle_stream();
    do_reset();
    out_tready = 1; got.delete(); n_settled = 0;
    start = 1; cyc(); start = 0;
    repeat (CLR_CYC) cyc();
    for (int v = 1; v <= 10; v++) begin
      strobe(OUT_DW'(v));
      if (v == 8) begin
        checks++;
        if (out_tvalid !== 1'b1 || out_tdata !== OUT_DW'(8)) begin failures++; $display("FAIL first_latency got=%b/%0d exp=1/8", out_tvalid, out_tdata); end
      end
      repeat ($urandom_range(0, 2)) cyc();
    end
    repeat (4) cyc();
    checks++; if (n_settled != 1) begin failures++; $display("FAIL settled_pulses got=%0d exp=1", n_settled); end
    checks++; if (got.size() != 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== OUT_DW'(8 + i)) begin failures++; $display("FAIL stream_val%0d got=%0d exp=%0d", i, got[i], 8 + i); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    go_run();
    out_tready = 0;
    for (int i = 0; i < 6; i++) begin
      strobe(OUT_DW'(100 + i));
      checks++;
      if (out_tvalid !== 1'b1 || out_tdata !== OUT_DW'(100)) begin failures++; $display("FAIL ovf_head%0d got=%b/%0d exp=1/100", i, out_tvalid, out_tdata); end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    got.delete(); out_tready = 1;
    repeat (6) cyc();
    checks++; if (got.size() != 4) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== OUT_DW'(100 + i)) begin failures++; $display("FAIL ovf_drain%0d got=%0d exp=%0d", i, got[i], 100 + i); end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    go_run();
    out_tready = 0;
    for (int i = 0; i < 4; i++) strobe(OUT_DW'(200 + i));
    out_tready = 1; got.delete();
    strobe(OUT_DW'(204));
    out_tready = 0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pushpop_ovf got=%b exp=0", overflow); end
    checks++; if (out_tdata !== OUT_DW'(201)) begin failures++; $display("FAIL pushpop_head got=%0d exp=201", out_tdata); end
    out_tready = 1;
    repeat (6) cyc();
    checks++; if (got.size() != 5) begin failures++; $display("FAIL pushpop_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== OUT_DW'(200 + i)) begin failures++; $display("FAIL pushpop_val%0d got=%0d exp=%0d", i, got[i], 200 + i); end
    end
  endtask

  task automatic test_stop_settle();
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (CLR_CYC) cyc();
    inp_samp_str = 1; #1;
    checks++; if (cic_inp_samp_str !== 1'b1) begin failures++; $display("FAIL settle_passthru got=%b exp=1", cic_inp_samp_str); end
    strobe(OUT_DW'(5));
    stop = 1; cyc(); stop = 0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", busy); end
    checks++; if (cic_inp_samp_str !== 1'b0) begin failures++; $display("FAIL stop_str got=%b exp=0", cic_inp_samp_str); end
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b0 || cic_clear !== 1'b0 || cic_inp_samp_str !== 1'b0) begin
        failures++; $display("FAIL startstop_c%0d got=%b%b%b exp=000", c, busy, cic_clear, cic_inp_samp_str);
      end
      cyc();
    end
    inp_samp_str = 0;
  endtask

  task automatic test_reset_in_run();
    do_reset();
    go_run();
    out_tready = 0;
    for (int i = 0; i < 3; i++) strobe(OUT_DW'(300 + i));
    checks++; if (out_tvalid !== 1'b1) begin failures++; $display("FAIL rr_prevalid got=%b exp=1", out_tvalid); end
    reset = 1; cyc(); reset = 0;
    checks++; if (out_tvalid !== 1'b0 || out_tdata !== '0) begin failures++; $display("FAIL rr_flush got=%b/%0d exp=0/0", out_tvalid, out_tdata); end
    out_tready = 1; got.delete();
    repeat (5) cyc();
    checks++; if (got.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL rr_after got=%0d/%b exp=0/0", got.size(), busy); end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int n = 0; n < 3000; n++) begin
      reset             = ($urandom_range(0, 299) == 0);
      start             = ($urandom_range(0, 7) == 0);
      stop              = ($urandom_range(0, 79) == 0);
      inp_samp_str      = $urandom_range(0, 1);
      inp_samp_data     = INP_DW'($urandom);
      cic_out_samp_str  = $urandom_range(0, 1);
      cic_out_samp_data = OUT_DW'($urandom);
      out_tready        = ($urandom_range(0, 9) < 7);
      #1;
      checks++;
      if (busy !== (m_ph != P_IDLE) || cic_clear !== (m_ph == P_CLEAR) ||
          cic_inp_samp_str !== (inp_samp_str && (m_ph == P_SETTLE || m_ph == P_RUN)) ||
          cic_inp_samp_data !== inp_samp_data || overflow !== m_ovf || settled !== m_settled ||
          out_tvalid !== (m_q.size() != 0) || out_tdata !== ((m_q.size() != 0) ? m_q[0] : '0)) begin
        failures++;
        if (bad < 10)
          $display("FAIL rand_cyc%0d got=b%b c%b s%b o%b st%b v%b d%h exp=ph%0d o%b st%b q%0d d%h",
                   n, busy, cic_clear, cic_inp_samp_str, overflow, settled, out_tvalid, out_tdata,
                   m_ph, m_ovf, m_settled, m_q.size(), (m_q.size() != 0) ? m_q[0] : '0);
        bad++;
      end
      cyc();
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_clear_seq();
    test_settle_stream();
    test_overflow();
    test_full_push_pop();
    test_stop_settle();
    test_reset_in_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_d_ctrl.md
CIC_D_CTRL -- requirements
Module: cic_d_ctrl

Interface
REQ-001 Param INP_DW, 18, input sample width passed to the decimator.
REQ-002 Param OUT_DW, 18, decimator output width and stream data width.
REQ-003 Param CIC_N, 7, decimator stage count.
REQ-004 Param CIC_M, 1, comb delay.
REQ-005 Param CLR_CYC, 2, cycles cic_clear is held high (>=1).
REQ-006 Param FIFO_DEPTH, 4, output buffer depth (power of two, >=2).
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start / stop  in  1 each  single-cycle run-control commands.
REQ-010 inp_samp_data  in  INP_DW  signed input sample; inp_samp_str  in  1  input strobe.
REQ-011 cic_inp_samp_data  out  INP_DW, cic_inp_samp_str  out  1, cic_clear  out  1  drive the decimator.
REQ-012 cic_out_samp_data  in  OUT_DW, cic_out_samp_str  in  1  decimator output.
REQ-013 out_tdata  out  OUT_DW, out_tvalid  out  1, out_tready  in  1  valid/ready output stream.
REQ-014 busy  out  1  state != IDLE; overflow  out  1  sticky drop flag; settled  out  1  one-cycle pulse on entering RUN.

Function
REQ-015 FSM states IDLE, CLEAR, SETTLE, RUN; state is registered.
REQ-016 IDLE + start=1 (stop=0) -> CLEAR next cycle; start outside IDLE is ignored.
REQ-017 CLEAR: cic_clear=1 for exactly CLR_CYC consecutive cycles, then SETTLE; cic_clear=0 in all other states.
REQ-018 Entering CLEAR loads settle counter with CIC_N*CIC_M and clears overflow.
REQ-019 SETTLE: each cic_out_samp_str decrements counter and the sample is discarded; strobe with counter==1 -> RUN next cycle with settled=1 for that one cycle.
REQ-020 RUN: each cic_out_samp_str pushes cic_out_samp_data into FIFO.
REQ-021 Push while FIFO full and no pop in the same cycle: sample dropped, overflow set; full with simultaneous pop: push accepted, no overflow.
REQ-022 stop=1 in any non-IDLE state -> IDLE next cycle; stop wins over simultaneous start; FIFO contents are retained and remain deliverable.
REQ-023 cic_inp_samp_data = inp_samp_data combinationally; cic_inp_samp_str = inp_samp_str only in SETTLE or RUN (registered state), else 0.
REQ-024 out_tvalid = FIFO non-empty; out_tdata = FIFO head; pop on out_tvalid & out_tready; out_tdata held stable while out_tvalid & !out_tready.
REQ-025 Latency: RUN cic_out_samp_str at cycle t with empty FIFO -> out_tvalid=1 at t+1.
REQ-026 Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-027 reset=1 at a clock edge: state IDLE, FIFO empty, counters 0, overflow 0, settled 0, busy 0, cic_clear 0, out_tvalid 0, out_tdata 0.
REQ-028 Reset mid-operation aborts any state immediately; discarded FIFO data is not delivered.

Structure
REQ-029 Package cic_pkg holds the FSM state enum and the clog2 helper function.
REQ-030 FIFO is sub-module cic_out_fifo (synchronous, DEPTH/DW parameters, full/empty outputs); FSM and settle counter live in cic_d_ctrl.

Verification
REQ-031 Reset then start with CLR_CYC=2: cic_clear high exactly cycles 1-2 after start, busy=1 from cycle 1.
REQ-032 CIC_N=7, CIC_M=1, 10 output strobes values 1..10: values 1..7 discarded, settled pulse once, stream delivers 8,9,10 in order.
REQ-033 RUN, out_tready=0, FIFO_DEPTH=4, 6 strobes: first 4 held, overflow=1, out_tdata stable; release ready: 4 values delivered.
REQ-034 FIFO full, push and pop same cycle: no overflow, occupancy stays 4.
REQ-035 stop during SETTLE then start and stop together: IDLE, cic_inp_samp_str=0 from the next cycle, no CLEAR entered.
REQ-036 reset asserted in RUN with 3 buffered samples: out_tvalid=0 next cycle, nothing delivered afterward.
